// File: rtl/load_use_scoreboard_pkg.sv
// load_use_scoreboard_pkg: ISA constants shared by the load-use hazard unit and its decoder
package load_use_scoreboard_pkg;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W = 4;
  localparam int INSTR_W = 16;
  localparam logic [3:0] OP_LW = 4'b1000;
  localparam logic [3:0] OP_SW = 4'b1001;
  localparam logic [3:0] OP_LHB = 4'b1010;
  localparam logic [3:0] OP_JR = 4'b1110;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/load_use_scoreboard_src_decode.sv
// load_use_scoreboard_src_decode: instruction to source-register usage decode
module load_use_scoreboard_src_decode
  import load_use_scoreboard_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic               rs_used,
  output logic [ADDR_W-1:0]  rs_addr,
  output logic               rt_used,
  output logic [ADDR_W-1:0]  rt_addr
);
  logic [3:0] op;
  always_comb begin
    op = instr[15:12];
    rs_used = !op[3] || op[3:1] == OP_LW[3:1] || op == OP_JR;
    rs_addr = instr[7:4];
    rt_used = op[3:2] == 2'b00 || op == OP_SW || op == OP_LHB;
    rt_addr = op[3] ? instr[11:8] : instr[3:0];
  end
endmodule

// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard: multi-cycle load-use hazard detection with per-register scoreboard
module load_use_scoreboard
  import load_use_scoreboard_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter bit ZERO_REG = 1'b1,
  parameter int STAT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INSTR_W-1:0]  instr_id,
  input  logic                id_valid,
  input  logic                ex_valid,
  input  logic                ex_mem_read,
  input  logic [ADDR_W-1:0]   ex_dst,
  input  logic                flush_ex,
  input  logic                freeze,
  output logic                stall,
  output logic                bubble_ex,
  output logic [NUM_REGS-1:0] pend_mask,
  output logic [STAT_W-1:0]   stall_cycles
);
  localparam int CNT_W = $clog2(LOAD_LAT + 1);
  logic rs_used, rt_used, rs_ok, rt_ok, ld, ex_hit, sb_hit;
  logic [ADDR_W-1:0] rs_addr, rt_addr;
  load_use_scoreboard_src_decode u_dec (
    .instr  (instr_id),
    .rs_used(rs_used),
    .rs_addr(rs_addr),
    .rt_used(rt_used),
    .rt_addr(rt_addr)
  );
  always_comb begin
    rs_ok = rs_used && (!ZERO_REG || rs_addr != REG_ZERO);
    rt_ok = rt_used && (!ZERO_REG || rt_addr != REG_ZERO);
    ld = ex_valid && ex_mem_read && !flush_ex && (!ZERO_REG || ex_dst != REG_ZERO);
    ex_hit = ld && ((rs_ok && ex_dst == rs_addr) || (rt_ok && ex_dst == rt_addr));
    sb_hit = (rs_ok && pend_mask[rs_addr]) || (rt_ok && pend_mask[rt_addr]);
    stall = id_valid && (ex_hit || sb_hit);
    bubble_ex = stall;
  end
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    logic [CNT_W-1:0] cnt;
    assign pend_mask[r] = cnt != '0;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (!freeze) cnt <= (ld && ex_dst == ADDR_W'(r)) ? CNT_W'(LOAD_LAT - 1) : cnt - CNT_W'(pend_mask[r]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cycles <= '0;
    else if (stall && !freeze && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
endmodule
